// File: rtl/nes_controller_responder_pkg.sv
// Shared types and constants for the NES controller responder: FSM state
// encoding and the standard controller button bit positions.
package nes_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      DONE
   } nes_resp_state_t;

   localparam int NES_NUM_BUTTONS = 8;

   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/nes_controller_responder_if.sv
// Pin-level bundle between the connector/button source and the responder.
// turbo_mask exists only when NES_RESP_TURBO_EN is defined.
interface nes_controller_responder_if
   import nes_pkg::*;
#(
   parameter int NUM_BITS = NES_NUM_BUTTONS
);

   logic                nes_latch;
   logic                nes_pulse;
   logic [NUM_BITS-1:0] buttons;
   logic                nes_data;
   logic                frame_done;
   logic                busy;
`ifdef NES_RESP_TURBO_EN
   logic [NUM_BITS-1:0] turbo_mask;

   modport master (
      output nes_latch, nes_pulse, buttons, turbo_mask,
      input  nes_data, frame_done, busy
   );

   modport slave (
      input  nes_latch, nes_pulse, buttons, turbo_mask,
      output nes_data, frame_done, busy
   );
`else
   modport master (
      output nes_latch, nes_pulse, buttons,
      input  nes_data, frame_done, busy
   );

   modport slave (
      input  nes_latch, nes_pulse, buttons,
      output nes_data, frame_done, busy
   );
`endif

endinterface

// File: rtl/nes_controller_responder_sync_edge.sv
// Multi-flop synchronizer for an asynchronous host line plus a registered
// rising-edge strobe; rise_o appears SYNC_STAGES+1 clocks after the pin edge.
module nes_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic din_i,
   output logic level_o,
   output logic rise_o
);

   // SYNC_STAGES must be at least 2 for metastability settling.
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   level_dly_q;
   logic                   rise_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour, forming a true shift chain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q      <= '0;
         level_dly_q <= 1'b0;
         rise_q      <= 1'b0;
      end else begin
         sync_q      <= {sync_q[SYNC_STAGES-2:0], din_i};
         level_dly_q <= sync_q[SYNC_STAGES-1];
         rise_q      <= sync_q[SYNC_STAGES-1] & ~level_dly_q;
      end
   end

   assign level_o = sync_q[SYNC_STAGES-1];
   assign rise_o  = rise_q;

endmodule

// File: rtl/nes_controller_responder.sv
// Device-side NES controller emulation (4021-style): captures buttons while
// latched, shifts them out active-low on host pulses. Optional turbo gating
// is enabled by defining NES_RESP_TURBO_EN.
module nes_controller_responder
   import nes_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int NUM_BITS    = NES_NUM_BUTTONS
`ifdef NES_RESP_TURBO_EN
   ,
   parameter int TURBO_DIV   = 4
`endif
) (
   input logic                     clk,
   input logic                     reset,
   nes_controller_responder_if.slave bus
);

   localparam int                CNT_W    = $clog2(NUM_BITS) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BITS);

   logic latch_s;
   logic latch_rise;
   logic pulse_s;
   logic pulse_rise;

   nes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
      .clk     (clk),
      .reset   (reset),
      .din_i   (bus.nes_latch),
      .level_o (latch_s),
      .rise_o  (latch_rise)
   );

   nes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pulse_sync (
      .clk     (clk),
      .reset   (reset),
      .din_i   (bus.nes_pulse),
      .level_o (pulse_s),
      .rise_o  (pulse_rise)
   );

   logic [NUM_BITS-1:0] capture;

`ifdef NES_RESP_TURBO_EN
   localparam int                 TCNT_W    = $clog2(TURBO_DIV + 1);
   localparam logic [TCNT_W-1:0] TCNT_WRAP = TCNT_W'(TURBO_DIV);

   logic              toggle_q, toggle_d;
   logic [TCNT_W-1:0] tcnt_q, tcnt_d;

   // The first TURBO_DIV frames read unmasked; every TURBO_DIV latches after
   // that the toggle flips, so masked buttons alternate in TURBO_DIV-frame runs.
   always_comb begin
      toggle_d = toggle_q;
      tcnt_d   = tcnt_q;
      if (latch_rise) begin
         if (tcnt_q == TCNT_WRAP) begin
            tcnt_d   = TCNT_W'(1);
            toggle_d = ~toggle_q;
         end else begin
            tcnt_d = tcnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         toggle_q <= 1'b0;
         tcnt_q   <= '0;
      end else begin
         toggle_q <= toggle_d;
         tcnt_q   <= tcnt_d;
      end
   end

   assign capture = bus.buttons & ~(bus.turbo_mask & {NUM_BITS{toggle_q}});
`else
   logic unused_latch_rise;
   assign unused_latch_rise = latch_rise;
   assign capture           = bus.buttons;
`endif

   nes_resp_state_t     state_q, state_d;
   logic [NUM_BITS-1:0] sr_q, sr_d;
   logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0]    bit_cnt_inc;
   logic                nes_data_q, nes_data_d;
   logic                frame_done_q, frame_done_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         sr_q         <= '0;
         bit_cnt_q    <= '0;
         nes_data_q   <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sr_q         <= sr_d;
         bit_cnt_q    <= bit_cnt_d;
         nes_data_q   <= nes_data_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bit_cnt_inc = bit_cnt_q + 1'b1;

   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d      = state_q;
      sr_d         = sr_q;
      bit_cnt_d    = bit_cnt_q;
      nes_data_d   = nes_data_q;
      frame_done_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            nes_data_d = 1'b1;
            if (latch_s) state_d = LOAD;
         end
         LOAD: begin
            sr_d       = capture;
            bit_cnt_d  = '0;
            nes_data_d = ~capture[BTN_A];
            if (!latch_s) state_d = SHIFT;
         end
         SHIFT: begin
            // Latch outranks a coincident pulse and discards the partial frame.
            if (latch_s) begin
               state_d = LOAD;
            end else if (pulse_rise) begin
               sr_d      = {1'b0, sr_q[NUM_BITS-1:1]};
               bit_cnt_d = bit_cnt_inc;
               if (bit_cnt_inc == LAST_CNT) begin
                  state_d      = DONE;
                  frame_done_d = 1'b1;
                  nes_data_d   = 1'b0;
               end else begin
                  nes_data_d = ~sr_q[1];
               end
            end
         end
         DONE: begin
            nes_data_d = 1'b0;
            if (latch_s) state_d = LOAD;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.busy       = (state_q == LOAD) || (state_q == SHIFT);
      bus.nes_data   = nes_data_q;
      bus.frame_done = frame_done_q;
   end

   logic unused_pulse_s;
   assign unused_pulse_s = pulse_s;

endmodule

// File: tb/tb_nes_controller_responder.sv
// Directed self-checking bench for nes_controller_responder (default build):
// idle/reset state, frame bit order, overrun pulses, re-latch, latch priority, async reset.
module tb_nes_controller_responder;
   import nes_pkg::*;

   localparam int SYNC_STAGES = 2;
   localparam int FD_LAT      = SYNC_STAGES + 2;

   logic clk;
   logic reset;
   int   n_total;
   int   n_pass;
   int   n_fail;
   int   fd_cnt;
   int   fd_at;
   int   fd_sum;

   nes_controller_responder_if bus ();

   nes_controller_responder #(.SYNC_STAGES(SYNC_STAGES)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pulse high 20 clk then low 20 clk; counts frame_done strobes and the
   // clock index (from the rising pin edge) of the last one seen.
   task automatic do_pulse(output int cnt, output int at);
      cnt = 0;
      at  = 0;
      bus.nes_pulse = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (bus.frame_done === 1'b1) begin
            cnt++;
            at = c;
         end
         if (c == 20) bus.nes_pulse = 1'b0;
      end
   endtask

   task automatic do_latch(input int high_clks);
      bus.nes_latch = 1'b1;
      repeat (high_clks) @(negedge clk);
      bus.nes_latch = 1'b0;
      repeat (20) @(negedge clk);
   endtask

   // exp_rd holds the host-sampled level of each bit, bit0 read first.
   task automatic shift_frame(input string tag, input logic [7:0] exp_rd);
      int c;
      int at;
      int total;
      int last_at;
      total   = 0;
      last_at = 0;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("%s_bit%0d", tag, i), 32'(bus.nes_data), 32'(exp_rd[i]));
         do_pulse(c, at);
         total += c;
         if (i == 7) last_at = at;
      end
      check({tag, "_fd_count"}, 32'(total), 32'd1);
      check({tag, "_fd_latency"}, 32'(last_at), 32'(FD_LAT));
      check({tag, "_data_after"}, 32'(bus.nes_data), 32'd0);
      check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      n_fail  = 0;
      reset         = 1'b1;
      bus.nes_latch = 1'b0;
      bus.nes_pulse = 1'b0;
      bus.buttons   = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_data", 32'(bus.nes_data), 32'd1);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_fd", 32'(bus.frame_done), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         check("idle_quiet", 32'({bus.nes_data, bus.busy, bus.frame_done}), 32'b100);
      end

      // A + Select pressed.
      bus.buttons   = 8'h05;
      bus.nes_latch = 1'b1;
      repeat (10) @(negedge clk);
      check("f1_load_busy", 32'(bus.busy), 32'd1);
      check("f1_load_data", 32'(bus.nes_data), 32'd0);
      repeat (10) @(negedge clk);
      bus.nes_latch = 1'b0;
      repeat (20) @(negedge clk);
      check("f1_shift_busy", 32'(bus.busy), 32'd1);
      shift_frame("f1", 8'hFA);

      // All pressed, 12 pulses: the 4 overrun reads stay 0.
      bus.buttons = 8'hFF;
      do_latch(20);
      fd_sum = 0;
      for (int i = 0; i < 12; i++) begin
         check($sformatf("f2_rd%0d", i), 32'(bus.nes_data), 32'd0);
         do_pulse(fd_cnt, fd_at);
         fd_sum += fd_cnt;
      end
      check("f2_fd_count", 32'(fd_sum), 32'd1);

      // Partial frame of 8'h01, then re-latch with buttons changing mid-latch.
      bus.buttons = 8'h01;
      do_latch(20);
      fd_sum = 0;
      check("f3_rd0", 32'(bus.nes_data), 32'd0);
      do_pulse(fd_cnt, fd_at);
      fd_sum += fd_cnt;
      check("f3_rd1", 32'(bus.nes_data), 32'd1);
      do_pulse(fd_cnt, fd_at);
      fd_sum += fd_cnt;
      check("f3_rd2", 32'(bus.nes_data), 32'd1);
      do_pulse(fd_cnt, fd_at);
      fd_sum += fd_cnt;
      bus.nes_latch = 1'b1;
      repeat (10) @(negedge clk);
      check("f4_load_old", 32'(bus.nes_data), 32'd0);
      bus.buttons = 8'h80;
      repeat (10) @(negedge clk);
      check("f4_load_new", 32'(bus.nes_data), 32'd1);
      bus.nes_latch = 1'b0;
      repeat (20) @(negedge clk);
      check("f3_no_fd", 32'(fd_sum), 32'd0);
      shift_frame("f4", 8'h7F);

      // Latch and pulse rise together mid-frame: LOAD wins.
      bus.buttons = 8'h3C;
      do_latch(20);
      check("f5_rd0", 32'(bus.nes_data), 32'd1);
      do_pulse(fd_cnt, fd_at);
      check("f5_rd1", 32'(bus.nes_data), 32'd1);
      do_pulse(fd_cnt, fd_at);
      check("f5_rd2", 32'(bus.nes_data), 32'd0);
      bus.buttons   = 8'hA6;
      bus.nes_latch = 1'b1;
      bus.nes_pulse = 1'b1;
      repeat (10) @(negedge clk);
      check("f5_coinc_busy", 32'(bus.busy), 32'd1);
      check("f5_coinc_data", 32'(bus.nes_data), 32'd1);
      check("f5_coinc_cnt", 32'(dut.bit_cnt_q), 32'd0);
      bus.nes_latch = 1'b0;
      bus.nes_pulse = 1'b0;
      repeat (20) @(negedge clk);
      shift_frame("f6", 8'h59);

      // Async reset after 4 bits, asserted between clock edges.
      bus.buttons = 8'hFF;
      do_latch(20);
      for (int i = 0; i < 4; i++) do_pulse(fd_cnt, fd_at);
      check("f7_pre_rst_data", 32'(bus.nes_data), 32'd0);
      #1 reset = 1'b1;
      #1;
      check("f7_rst_data", 32'(bus.nes_data), 32'd1);
      check("f7_rst_busy", 32'(bus.busy), 32'd0);
      check("f7_rst_state", 32'(dut.state_q), 32'(IDLE));
      @(negedge clk);
      check("f7_rst_hold", 32'(bus.nes_data), 32'd1);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      bus.buttons = 8'h96;
      do_latch(20);
      shift_frame("f8", 8'h69);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
